alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Upstream command stage for the 8-bit registered ALU (ADD/SUB/MUL/DIV/AND/XOR, 16-bit Result, C_out, Z_flag).
- Buffers operation requests from a valid/ready source, drives ALU operands one command at a time, and captures the ALU's registered outputs.
- Returns each result with its tag over a valid/ready response channel.
- Screens illegal opcodes and divide-by-zero so the ALU never sees them.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TAG_W, 4, width of the user tag carried from command to response.

Ports:
- CLK  in  1  clock, shared with the ALU.
- Reset  in  1  synchronous, active-high reset; also drives the ALU's Reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  4  opcode.
- cmd_cin  in  1  carry-in, used by ADD only.
- cmd_tag  in  TAG_W  user tag.
- alu_a  out  8  to ALU A.
- alu_b  out  8  to ALU B.
- alu_op  out  4  to ALU op_code.
- alu_cin  out  1  to ALU C_in.
- alu_result  in  16  from ALU Result.
- alu_cout  in  1  from ALU C_out.
- alu_zero  in  1  from ALU Z_flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  16  captured result.
- rsp_cout  out  1  captured carry.
- rsp_zero  out  1  captured zero flag.
- rsp_err  out  1  command rejected, not issued.
- rsp_tag  out  TAG_W  tag of the command.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- stat_issued  out  16  see Optional Feature.
- stat_errors  out  16  see Optional Feature.

Behaviour:
- Reset: CLK is the clock. Reset is synchronous and active-high, sampled on the CLK rising edge; it overrides all other activity.
- Reset values:
  - FIFO emptied; cmd_ready=1.
  - FSM=IDLE.
  - alu_a/alu_b/alu_op/alu_cin=0, which is ADD 0+0.
  - rsp_valid=0; rsp_result=0, rsp_cout=0, rsp_zero=0, rsp_err=0, rsp_tag=0.
  - busy=0; stats=0.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = !full; registered count only, no same-cycle bypass, so a pop does not free a slot within the same cycle.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
  - The FIFO pops only in IDLE with the FIFO non-empty.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE, FIFO non-empty: pop the head.
    - Legal head (op<=5, and not (op==3 && b==0)): load alu_* registers, go to ISSUE.
    - Illegal head: set rsp_err=1, rsp_result=0, rsp_cout=0, rsp_zero=0, rsp_tag=tag; go to RESP. alu_* registers are unchanged.
  - ISSUE: alu_* stable; the ALU registers at the end of this cycle. Next state CAPTURE.
  - CAPTURE: sample alu_result/alu_cout/alu_zero into rsp_*; rsp_err=0. Next state RESP.
  - RESP: rsp_valid=1. All rsp_* held stable until rsp_ready. On accept, go to IDLE.
- Timing:
  - Head popped at the end of cycle T gives rsp_valid high from T+3.
  - Peak throughput is 1 command per 4 cycles. An error response takes 2 cycles with rsp_ready tied high.
  - rsp_valid is never deasserted without acceptance.
- Simultaneous push and pop: both happen and count is unchanged.
- Reset mid-operation: the in-flight command and all queued commands are discarded; no response is produced.
- alu_* registers are held between commands. The ALU output is not consumed outside CAPTURE.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- With the macro defined:
  - stat_issued increments on each ISSUE→CAPTURE transition.
  - stat_errors increments on each illegal pop.
  - Both counters are 16-bit, saturate at 0xFFFF, and clear on Reset.
- Without the macro: stat_issued and stat_errors are tied to 0 and no counter flops are built.

Decomposition:
- Package alu_pkg holds:
  - opcode enum: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, XOR=5.
  - OP_LAST=5.
  - packed struct alu_cmd_t {a, b, op, cin, tag}.
  - FSM state enum.
  - function is_legal(cmd).
- One sub-module, alu_cmd_fifo: synchronous FIFO of alu_cmd_t with DEPTH, push/pop, full/empty.

Test Plan:
- Reset, then ADD a=0xF0 b=0x20 cin=1 tag=3 with rsp_ready=1 → rsp_valid 3 cycles after pop; result=0x0111, cout=1, zero=0, err=0, tag=3.
- MUL a=0xFF b=0xFF → result=0xFE01, cout=0. Then AND a=0x0F b=0xF0 → result=0, zero=1.
- DIV a=9 b=0 tag=5 → err=1, result=0, tag=5, stat_errors=1 (macro on). Then op=0x7 → err=1 and alu_op unchanged.
- Hold rsp_ready=0 and push 5 commands at DEPTH=4 → cmd_ready drops after the FIFO fills; rsp fields stay stable; releasing rsp_ready drains responses in order with matching tags.
- Assert Reset for 1 cycle during CAPTURE with 2 commands queued → no response; rsp_valid=0; cmd_ready=1; busy=0; alu_op=0.
- Continuous cmd_valid with a 1-cycle push and pop overlap when the FIFO is half full → count stable and no command lost or duplicated; the scoreboard matches every tag.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU command stage: opcodes, command record,
// controller states and the legality screen applied before issue.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5
  } alu_op_e;

  localparam logic [3:0] OP_LAST = 4'd5;

  // Tag storage width inside a queued command; the top-level TAG_W must
  // not exceed this, narrower tags are zero-extended on the way in.
  localparam int ALU_TAG_W = 4;

  typedef struct packed {
    logic [7:0]           a;
    logic [7:0]           b;
    logic [3:0]           op;
    logic                 cin;
    logic [ALU_TAG_W-1:0] tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } ctrl_state_e;

  // A command may reach the ALU only with a known opcode and a non-zero divisor.
  function automatic logic is_legal(input alu_cmd_t cmd);
    return (cmd.op <= OP_LAST) && !((cmd.op == OP_DIV) && (cmd.b == 8'd0));
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t; DEPTH must be a power of two so the
// pointers wrap naturally. Head entry is presented combinationally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     CLK,
  input  logic     Reset,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]  COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  alu_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Entry storage needs no reset: the count decides which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a push and pop in the same cycle leave count unchanged.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command stage in front of the registered 8-bit ALU: queues requests,
// issues one at a time, captures the ALU's registered outputs and returns
// them with the request tag. Illegal opcodes and divide-by-zero are answered
// with an error response and never reach the ALU.
// Optional macro ALU_ISSUE_STATS_EN builds saturating issue/error counters;
// without it stat_issued and stat_errors are constant zero.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_cin,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [15:0]      alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_errors
);

  alu_cmd_t    push_cmd;
  alu_cmd_t    head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        head_legal;
  ctrl_state_e state;
  ctrl_state_e next_state;

  assign push_cmd   = '{a: cmd_a, b: cmd_b, op: cmd_op, cin: cmd_cin, tag: ALU_TAG_W'(cmd_tag)};
  assign cmd_ready  = !fifo_full;
  assign head_legal = is_legal(head);
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .Reset    (Reset),
    .push     (cmd_valid && cmd_ready),
    .push_data(push_cmd),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and pop decision; the FIFO is only drained from IDLE.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = head_legal ? ISSUE : RESP;
        end
      end
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ALU operand and response registers; nothing here changes while in RESP.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_cin    <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      if (fifo_pop) rsp_tag <= TAG_W'(head.tag);
      if (fifo_pop && head_legal) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_op  <= head.op;
        alu_cin <= head.cin;
      end
      if (fifo_pop && !head_legal) begin
        rsp_err    <= 1'b1;
        rsp_result <= '0;
        rsp_cout   <= 1'b0;
        rsp_zero   <= 1'b0;
      end
      if (state == CAPTURE) begin
        rsp_result <= alu_result;
        rsp_cout   <= alu_cout;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issued_q;
  logic [15:0] errors_q;
  logic        issue_done;
  logic        err_pop;

  assign issue_done  = (state == ISSUE);
  assign err_pop     = fifo_pop && !head_legal;
  assign stat_issued = issued_q;
  assign stat_errors = errors_q;

  // Saturating counters of issued commands and rejected commands.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      issued_q <= '0;
      errors_q <= '0;
    end else begin
      if (issue_done && (issued_q != 16'hFFFF)) issued_q <= issued_q + 16'd1;
      if (err_pop && (errors_q != 16'hFFFF))    errors_q <= errors_q + 16'd1;
    end
  end
`else
  assign stat_issued = '0;
  assign stat_errors = '0;
`endif

endmodule
